pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register: successor to the fixed ID/EX latch.
//  Carries an opaque PAYLOAD_W-bit bundle (aluop|alusel|reg1|reg2|wd|wreg for ID/EX)
//  with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer.
//  Sits between any two pipeline stages; downstream stalls back-pressure upstream
//  without a combinational ready path (SKID_EN=1).
// PARAMETERS
//  PAYLOAD_W  81        payload width in bits (ID/EX bundle: 8+3+32+32+5+1)
//  NOP_VALUE  81'd0     payload presented when no valid beat (bubble encoding)
//  SKID_EN    1         1 = main+skid regs, registered up_ready; 0 = single reg
//  CNT_W      16        width of saturating stall counter
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          reset, synchronous, active-high
//  flush        in   1          synchronous kill of all held beats
//  up_valid     in   1          upstream beat valid
//  up_ready     out  1          stage can accept a beat this cycle
//  up_data      in   PAYLOAD_W  upstream payload
//  dn_valid     out  1          beat available downstream
//  dn_ready     in   1          downstream accepts (0 = stall)
//  dn_data      out  PAYLOAD_W  downstream payload; NOP_VALUE when dn_valid=0
//  occupancy    out  2          beats held: 0,1,2
//  stall_cnt    out  CNT_W      cycles with dn_valid=1 & dn_ready=0, saturating
// BEHAVIOUR
//  - up_fire = up_valid&up_ready; dn_fire = dn_valid&dn_ready. Beats never lost,
//    duplicated or reordered. Min latency up_fire -> dn_valid: 1 cycle.
//  - Reset (rst=1 at edge): state EMPTY, main/skid regs <= NOP_VALUE, dn_valid=0,
//    occupancy=0, stall_cnt=0, up_ready=1 next cycle. Reset beats everything.
//  - SKID_EN=1 FSM (occupancy = state):
//    EMPTY: up_fire -> ONE, main<=up_data.
//    ONE:   up_fire&dn_fire -> ONE, main<=up_data; up_fire&!dn_fire -> FULL,
//           skid<=up_data; !up_fire&dn_fire -> EMPTY; else hold.
//    FULL:  dn_fire -> ONE, main<=skid, skid<=NOP_VALUE; else hold.
//    up_ready = (state!=FULL), driven from a flop, no path from dn_ready.
//  - SKID_EN=0: one reg; up_ready = !dn_valid | dn_ready (combinational);
//    occupancy never exceeds 1.
//  - dn_valid = (state!=EMPTY); dn_data = main when valid else NOP_VALUE.
//  - flush (rst=0): next state EMPTY, regs <= NOP_VALUE; any same-cycle up beat is
//    discarded even if up_ready=1; a same-cycle dn_fire still counts as delivered
//    downstream. stall_cnt unaffected by flush.
//  - stall_cnt: +1 each cycle dn_valid&!dn_ready, holds at 2^CNT_W-1, never wraps.
//  - Payload bits never interpreted; any PAYLOAD_W>=1 legal.
// TESTING
//  1 Reset: drive rst=1 two cycles with random up_*. -> dn_valid=0, dn_data=0,
//    occupancy=0, up_ready=1, stall_cnt=0 on first cycle after release.
//  2 Streaming: dn_ready=1, up_valid=1, payloads 1..100 -> dn_data 1..100 in order,
//    one per cycle after 1-cycle latency, occupancy stays 1, stall_cnt=0.
//  3 Back-pressure: stream 0xA1,0xA2,0xA3 with dn_ready=0 -> occupancy 1,2,2,
//    up_ready=0 from 3rd cycle, 0xA3 not accepted; release -> 0xA1,0xA2,0xA3 out,
//    stall_cnt = stalled cycles exactly.
//  4 Flush while FULL plus concurrent up beat 0x55 -> next cycle dn_valid=0,
//    occupancy=0, dn_data=NOP_VALUE, 0x55 never appears downstream.
//  5 Saturation: CNT_W=4, hold dn_valid=1, dn_ready=0 for 20 cycles -> stall_cnt
//    reaches 15 and holds.
//  6 SKID_EN=0 build, random valid/ready 10k cycles vs scoreboard -> no loss/dup,
//    occupancy<=1, up_ready == !dn_valid|dn_ready every cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating downstream-stall counter.
module pipe_stage_skid #(
  parameter int unsigned          PAYLOAD_W = 81,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
  parameter bit                   SKID_EN   = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic [PAYLOAD_W-1:0] w_main_nxt;
  logic [PAYLOAD_W-1:0] w_skid_nxt;
  logic                 r_up_ready;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic                 w_dn_valid;
  logic                 w_up_fire;
  logic                 w_dn_fire;

  // Handshake decode; without the skid slot, ready must look through to dn_ready.
  assign w_dn_valid = (r_state != ST_EMPTY);
  assign up_ready   = SKID_EN ? r_up_ready : (!w_dn_valid || dn_ready);
  assign w_up_fire  = up_valid && up_ready;
  assign w_dn_fire  = w_dn_valid && dn_ready;

  // Next-state and register-update logic; flush discards everything held.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP_VALUE;
      w_skid_nxt  = NOP_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_up_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = up_data;
          end
        end
        ST_ONE: begin
          if (w_up_fire && w_dn_fire) begin
            w_main_nxt = up_data;
          end else if (w_up_fire && SKID_EN) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = up_data;
          end else if (w_dn_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_VALUE;
          end
        end
        ST_FULL: begin
          if (w_dn_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP_VALUE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP_VALUE;
          w_skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // State and payload registers; up_ready is precomputed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= NOP_VALUE;
      r_skid     <= NOP_VALUE;
      r_up_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_up_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Saturating count of cycles where a held beat is refused downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_dn_valid && !dn_ready && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign dn_valid  = w_dn_valid;
  assign dn_data   = w_dn_valid ? r_main : NOP_VALUE;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid build (81-bit, 4-bit stall counter) and a
// single-register build (16-bit) run against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int unsigned SK_W   = 81;
  localparam int unsigned SK_CNT = 4;
  localparam int unsigned NS_W   = 16;
  localparam int unsigned NS_CNT = 16;

  logic clk = 1'b0;
  logic rst;

  logic              sk_flush, sk_up_valid, sk_up_ready, sk_dn_valid, sk_dn_ready;
  logic [SK_W-1:0]   sk_up_data, sk_dn_data;
  logic [1:0]        sk_occ;
  logic [SK_CNT-1:0] sk_stall;

  logic              ns_flush, ns_up_valid, ns_up_ready, ns_dn_valid, ns_dn_ready;
  logic [NS_W-1:0]   ns_up_data, ns_dn_data;
  logic [1:0]        ns_occ;
  logic [NS_CNT-1:0] ns_stall;

  always #5 clk = ~clk;

  pipe_stage_skid #(.PAYLOAD_W(SK_W), .NOP_VALUE('0), .SKID_EN(1'b1), .CNT_W(SK_CNT)) u_sk (
    .clk(clk), .rst(rst), .flush(sk_flush),
    .up_valid(sk_up_valid), .up_ready(sk_up_ready), .up_data(sk_up_data),
    .dn_valid(sk_dn_valid), .dn_ready(sk_dn_ready), .dn_data(sk_dn_data),
    .occupancy(sk_occ), .stall_cnt(sk_stall)
  );

  pipe_stage_skid #(.PAYLOAD_W(NS_W), .NOP_VALUE('0), .SKID_EN(1'b0), .CNT_W(NS_CNT)) u_ns (
    .clk(clk), .rst(rst), .flush(ns_flush),
    .up_valid(ns_up_valid), .up_ready(ns_up_ready), .up_data(ns_up_data),
    .dn_valid(ns_dn_valid), .dn_ready(ns_dn_ready), .dn_data(ns_dn_data),
    .occupancy(ns_occ), .stall_cnt(ns_stall)
  );

  // Reference model: queue holds accepted beats in order; front is what must appear.
  logic [SK_W-1:0] sk_q[$];
  logic [NS_W-1:0] ns_q[$];
  int unsigned     sk_stall_m;
  int unsigned     ns_stall_m;
  bit              known = 1'b0;
  int              total = 0;
  int              bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs against the model, then advance the model by one clock edge.
  task automatic model_cycle();
    logic            sk_v, sk_r, ns_v, ns_r;
    logic [SK_W-1:0] sk_exp;
    logic [NS_W-1:0] ns_exp;
    sk_v   = (sk_q.size() != 0);
    sk_r   = (sk_q.size() != 2);
    ns_v   = (ns_q.size() != 0);
    ns_r   = !ns_v || ns_dn_ready;
    sk_exp = '0;
    ns_exp = '0;
    if (sk_v) sk_exp = sk_q[0];
    if (ns_v) ns_exp = ns_q[0];
    if (known) begin
      chk("sk_occupancy", 128'(sk_occ), 128'(sk_q.size()));
      chk("sk_dn_valid", 128'(sk_dn_valid), 128'(sk_v));
      chk("sk_dn_data", 128'(sk_dn_data), 128'(sk_exp));
      chk("sk_up_ready", 128'(sk_up_ready), 128'(sk_r));
      chk("sk_stall_cnt", 128'(sk_stall), 128'(sk_stall_m));
      chk("ns_occupancy", 128'(ns_occ), 128'(ns_q.size()));
      chk("ns_dn_valid", 128'(ns_dn_valid), 128'(ns_v));
      chk("ns_dn_data", 128'(ns_dn_data), 128'(ns_exp));
      chk("ns_up_ready", 128'(ns_up_ready), 128'(ns_r));
      chk("ns_stall_cnt", 128'(ns_stall), 128'(ns_stall_m));
    end
    if (rst) begin
      sk_q.delete();
      ns_q.delete();
      sk_stall_m = 0;
      ns_stall_m = 0;
      known      = 1'b1;
    end else begin
      if (sk_v && !sk_dn_ready && sk_stall_m != 15) sk_stall_m++;
      if (ns_v && !ns_dn_ready && ns_stall_m != 65535) ns_stall_m++;
      if (sk_v && sk_dn_ready) void'(sk_q.pop_front());
      if (ns_v && ns_dn_ready) void'(ns_q.pop_front());
      if (sk_flush) sk_q.delete();
      else if (sk_up_valid && sk_r) sk_q.push_back(sk_up_data);
      if (ns_flush) ns_q.delete();
      else if (ns_up_valid && ns_r) ns_q.push_back(ns_up_data);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sk_drive(input logic v, input logic [SK_W-1:0] d, input logic r, input logic f);
    sk_up_valid = v;
    sk_up_data  = d;
    sk_dn_ready = r;
    sk_flush    = f;
  endtask

  initial begin
    rst = 1'b1;
    sk_drive(1'b0, '0, 1'b0, 1'b0);
    ns_flush = 1'b0; ns_up_valid = 1'b0; ns_up_data = '0; ns_dn_ready = 1'b0;

    // Reset with random upstream activity
    for (int i = 0; i < 2; i++) begin
      sk_drive(1'($urandom_range(0, 1)), SK_W'({$urandom, $urandom, $urandom}), 1'($urandom_range(0, 1)), 1'b0);
      ns_up_valid = 1'($urandom_range(0, 1));
      ns_up_data  = 16'($urandom);
      ns_dn_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    ns_up_valid = 1'b0; ns_dn_ready = 1'b1;
    chk("rst_dn_valid", 128'(sk_dn_valid), 128'(0));
    chk("rst_dn_data", 128'(sk_dn_data), 128'(0));
    chk("rst_occupancy", 128'(sk_occ), 128'(0));
    chk("rst_up_ready", 128'(sk_up_ready), 128'(1));
    chk("rst_stall_cnt", 128'(sk_stall), 128'(0));
    chk("rst_ns_dn_valid", 128'(ns_dn_valid), 128'(0));
    step();

    // Streaming 1..100 with downstream always ready
    for (int i = 1; i <= 100; i++) begin
      sk_drive(1'b1, SK_W'(i), 1'b1, 1'b0);
      step();
      chk("stream_occupancy", 128'(sk_occ), 128'(1));
      chk("stream_dn_data", 128'(sk_dn_data), 128'(i));
    end
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_stall_cnt", 128'(sk_stall), 128'(0));
    chk("stream_drained", 128'(sk_occ), 128'(0));

    // Back-pressure: A1, A2 accepted, A3 refused while full
    sk_drive(1'b1, SK_W'(8'hA1), 1'b0, 1'b0);
    step();
    chk("bp_occ_1", 128'(sk_occ), 128'(1));
    sk_drive(1'b1, SK_W'(8'hA2), 1'b0, 1'b0);
    step();
    chk("bp_occ_2", 128'(sk_occ), 128'(2));
    chk("bp_up_ready", 128'(sk_up_ready), 128'(0));
    sk_drive(1'b1, SK_W'(8'hA3), 1'b0, 1'b0);
    step();
    chk("bp_occ_3", 128'(sk_occ), 128'(2));
    chk("bp_dn_data", 128'(sk_dn_data), 128'(8'hA1));
    step();
    chk("bp_stall_cnt", 128'(sk_stall), 128'(3));
    sk_drive(1'b1, SK_W'(8'hA3), 1'b1, 1'b0);
    step();
    chk("bp_release_a2", 128'(sk_dn_data), 128'(8'hA2));
    step();
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_release_a3", 128'(sk_dn_data), 128'(8'hA3));
    step();
    chk("bp_stall_final", 128'(sk_stall), 128'(3));

    // Flush while full with a concurrent upstream beat
    sk_drive(1'b1, SK_W'(8'hB1), 1'b0, 1'b0);
    step();
    sk_drive(1'b1, SK_W'(8'hB2), 1'b0, 1'b0);
    step();
    chk("fl_full", 128'(sk_occ), 128'(2));
    sk_drive(1'b1, SK_W'(8'h55), 1'b0, 1'b1);
    step();
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    chk("fl_dn_valid", 128'(sk_dn_valid), 128'(0));
    chk("fl_occupancy", 128'(sk_occ), 128'(0));
    chk("fl_dn_data", 128'(sk_dn_data), 128'(0));
    step();
    chk("fl_no_55", 128'(sk_dn_valid), 128'(0));

    // Flush in ONE with a same-cycle delivery and a discarded 0x55
    sk_drive(1'b1, SK_W'(8'hC1), 1'b0, 1'b0);
    step();
    sk_drive(1'b1, SK_W'(8'h55), 1'b1, 1'b1);
    step();
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    chk("fl1_occupancy", 128'(sk_occ), 128'(0));
    step();

    // Stall counter saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    sk_drive(1'b1, SK_W'(8'hD1), 1'b0, 1'b0);
    step();
    sk_drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", 128'(sk_stall), 128'(15));
    step();
    chk("sat_hold", 128'(sk_stall), 128'(15));
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Random valid/ready on both builds, occasional flush
    for (int i = 0; i < 10000; i++) begin
      sk_drive(1'($urandom_range(0, 1)), SK_W'({$urandom, $urandom, $urandom}),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      ns_up_valid = 1'($urandom_range(0, 1));
      ns_up_data  = 16'($urandom);
      ns_dn_ready = 1'($urandom_range(0, 1));
      ns_flush    = 1'($urandom_range(0, 49) == 0);
      step();
    end
    sk_drive(1'b0, '0, 1'b1, 1'b0);
    ns_up_valid = 1'b0; ns_dn_ready = 1'b1; ns_flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("drain_sk", 128'(sk_occ), 128'(0));
    chk("drain_ns", 128'(ns_occ), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
